// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader.
// Optional checksum trailer is enabled by PROGRAM_LOADER_CHECKSUM_EN.
package loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CHECK,
        FINISH
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_LEN,
        ERR_SUM
    } err_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction RAM write port of the loader.
// master = stream source / RAM side, slave = loader.
interface program_loader_if
    import loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int WORD_W = BYTES_PER_WORD * 8
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/program_loader_word_assembler.sv
// word_assembler: packs four bytes into a little-endian word.
// word/word_valid are valid in the cycle the 4th byte is presented.
module word_assembler
    import loader_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          byte_valid,
    input  logic [7:0]                    data_byte,
    output logic [BYTES_PER_WORD*8-1:0]   word,
    output logic                          word_valid
);
    logic [1:0]  idx;
    logic [23:0] low;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
            low <= '0;
        end else if (clear) begin
            idx <= '0;
            low <= '0;
        end else if (byte_valid) begin
            idx <= idx + 2'd1;
            unique case (idx)
                2'd0:    low[7:0]   <= data_byte;
                2'd1:    low[15:8]  <= data_byte;
                2'd2:    low[23:16] <= data_byte;
                default: ;
            endcase
        end
    end

    // Top byte is taken straight from the input so the word is ready on byte 4.
    assign word       = {data_byte, low};
    assign word_valid = byte_valid && (idx == 2'd3);
endmodule

// File: rtl/program_loader.sv
// program_loader: length-prefixed byte stream -> instruction RAM writes.
// Define PROGRAM_LOADER_CHECKSUM_EN for the mod-256 checksum trailer.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int WORD_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    program_loader_if.slave  bus,
    output logic             cpu_reset,
    output logic             busy,
    output logic             done,
    output logic             err
);
    state_t            state;
    err_t              cause;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  n;
    logic [ADDR_W:0]   widx;
    logic              take;
    logic              len_bad;
    logic              last_word;
    logic              word_valid;
    logic [31:0]       word;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]        sum;
`endif

    assign take      = bus.rx_valid && bus.rx_ready;
    assign n         = {bus.rx_data, len[7:0]};
    assign len_bad   = (n == '0) || (32'(n) > (32'd1 << ADDR_W));
    assign last_word = (32'(widx) + 32'd1) == 32'(len);
    assign err       = (cause != ERR_NONE);

    word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (start && state == IDLE),
        .byte_valid (take && state == DATA),
        .data_byte  (bus.rx_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cause         <= ERR_NONE;
            len           <= '0;
            widx          <= '0;
            bus.rx_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            cpu_reset     <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum           <= '0;
`endif
        end else begin
            bus.mem_we <= 1'b0;
            unique case (state)
                IDLE: if (start) begin
                    state        <= LEN_LO;
                    bus.rx_ready <= 1'b1;
                    busy         <= 1'b1;
                    done         <= 1'b0;
                    cause        <= ERR_NONE;
                    cpu_reset    <= 1'b1;
                    widx         <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    sum          <= '0;
`endif
                end
                LEN_LO: if (take) begin
                    len[7:0] <= bus.rx_data;
                    state    <= LEN_HI;
                end
                LEN_HI: if (take) begin
                    if (len_bad) begin
                        state        <= IDLE;
                        bus.rx_ready <= 1'b0;
                        busy         <= 1'b0;
                        cause        <= ERR_LEN;
                    end else begin
                        len[15:8] <= bus.rx_data;
                        state     <= DATA;
                    end
                end
                DATA: if (take) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    sum <= sum + bus.rx_data;
`endif
                    if (word_valid) begin
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= widx[ADDR_W-1:0];
                        bus.mem_wdata <= WORD_W'(word);
                        widx          <= widx + 1'b1;
                        if (last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                            state        <= CHECK;
`else
                            state        <= FINISH;
                            bus.rx_ready <= 1'b0;
`endif
                        end
                    end
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                CHECK: if (take) begin
                    bus.rx_ready <= 1'b0;
                    if (bus.rx_data == sum) begin
                        state <= FINISH;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cause <= ERR_SUM;
                    end
                end
`endif
                FINISH: begin
                    state     <= IDLE;
                    done      <= 1'b1;
                    cpu_reset <= 1'b0;
                    busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader against a stream-level model.
// Honours PROGRAM_LOADER_CHECKSUM_EN to append/verify the trailer byte.
module tb_program_loader;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic cpu_reset, busy, done, err;

    program_loader_if #(.ADDR_W(ADDR_W), .WORD_W(32)) bus ();

    program_loader #(.ADDR_W(ADDR_W), .WORD_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    logic [63:0] wr_q[$];
    logic [63:0] exp_q[$];
    logic [7:0]  stream[$];
    bit prev_we = 1'b0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            check("we_spacing", 64'(prev_we), 64'd0);
            wr_q.push_back({22'd0, bus.mem_addr, bus.mem_wdata});
        end
        prev_we = (bus.mem_we === 1'b1);
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit ok = 1'b0;
        if (gap) begin
            bus.rx_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = bus.rx_ready;
        end
        check("rx_accept", 64'(ok), 64'd1);
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
    endtask

    task automatic add_trailer(input bit good);
        logic [7:0] s = 8'd0;
        for (int i = 2; i < stream.size(); i++) s += stream[i];
        stream.push_back(good ? s : s + 8'd1);
    endtask

    task automatic mk_stream(input int n, input bit good);
        stream.delete();
        stream.push_back(8'(n));
        stream.push_back(8'(n >> 8));
        if (n >= 1 && n <= DEPTH) begin
            for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom));
            if (CK) add_trailer(good);
        end
    endtask

    task automatic run_load(input string name, input bit gap,
                            input bit mid_start);
        int n, nsend, cyc;
        bit len_ok, ok;
        logic [7:0] s;
        logic [31:0] w;
        n      = {stream[1], stream[0]};
        len_ok = (n != 0) && (n <= DEPTH);
        s      = 8'd0;
        exp_q.delete();
        if (len_ok) begin
            for (int k = 0; k < n; k++) begin
                w = {stream[2+4*k+3], stream[2+4*k+2],
                     stream[2+4*k+1], stream[2+4*k]};
                s += w[7:0] + w[15:8] + w[23:16] + w[31:24];
                exp_q.push_back({32'(k), w});
            end
        end
        ok = len_ok;
        if (len_ok && CK) ok = (stream[2+4*n] == s);
        nsend = len_ok ? 2 + 4 * n + int'(CK) : 2;
        wr_q.delete();
        pulse_start();
        check({name, "_start"}, 64'({busy, bus.rx_ready}), 64'd3);
        fork
            for (int i = 0; i < nsend; i++) send_byte(stream[i], gap);
            if (mid_start) begin
                repeat (6) @(posedge clk);
                #1 start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        join
        cyc = 0;
        while (busy && cyc < 64) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({name, "_lat"}, 64'(cyc), ok ? 64'd1 : 64'd0);
        check({name, "_done"}, 64'(done), 64'(ok));
        check({name, "_err"}, 64'(err), 64'(!ok));
        check({name, "_cpurst"}, 64'(cpu_reset), 64'(!ok));
        check({name, "_idle_rdy"}, 64'(bus.rx_ready), 64'd0);
        @(negedge clk);
        check({name, "_nwr"}, 64'(wr_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
            check({name, "_wr"}, wr_q[i], exp_q[i]);
        @(posedge clk); #1;
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'd0;
        repeat (3) @(posedge clk); #1;
        reset = 1'b0;
        check("rst_cpurst", 64'(cpu_reset), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_we", 64'(bus.mem_we), 64'd0);
        check("rst_rdy", 64'(bus.rx_ready), 64'd0);
        check("rst_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_wdata", 64'(bus.mem_wdata), 64'd0);

        stream = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                   8'hEF, 8'hBE, 8'hAD, 8'hDE};
        if (CK) add_trailer(1'b1);
        run_load("two", 1'b0, 1'b0);
        if (wr_q.size() == 2) begin
            check("two_w0", wr_q[0], 64'h0000_0000_1234_5678);
            check("two_w1", wr_q[1], 64'h0000_0001_DEAD_BEEF);
        end

        stream = '{8'h00, 8'h00};
        run_load("len0", 1'b0, 1'b0);
        stream = '{8'h01, 8'h04};
        run_load("len1025", 1'b0, 1'b0);

        stream = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        if (CK) add_trailer(1'b1);
        run_load("gap", 1'b1, 1'b1);

        wr_q.delete();
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_cpurst", 64'(cpu_reset), 64'd1);
        reset = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("mid_rst_nwr", 64'(wr_q.size()), 64'd0);
        stream = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        if (CK) add_trailer(1'b1);
        run_load("fresh", 1'b0, 1'b0);
        if (wr_q.size() == 1)
            check("fresh_w0", wr_q[0], 64'h0000_0000_DDCC_BBAA);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        stream = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
        run_load("sum_ok", 1'b0, 1'b0);
        check("sum_ok_flag", 64'(done), 64'd1);
        stream = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
        run_load("sum_bad", 1'b0, 1'b0);
        check("sum_bad_flag", 64'({err, cpu_reset}), 64'd3);
`endif

        mk_stream(DEPTH, 1'b1);
        run_load("max", 1'b0, 1'b0);

        for (int it = 0; it < 12; it++) begin
            int r, n;
            r = $urandom_range(0, 9);
            if (r == 0)      n = 0;
            else if (r == 1) n = DEPTH + 1 + $urandom_range(0, 64);
            else if (r == 2) n = 16'hFFFF;
            else             n = $urandom_range(1, 6);
            mk_stream(n, $urandom_range(0, 3) != 0);
            run_load("rnd", 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/program_loader.md
# program_loader

Byte-stream program loader that writes the instruction memory of the single-cycle processor. It receives a length-prefixed stream of bytes over a valid/ready interface and packs them into 32-bit little-endian words. Each word is written sequentially into the instruction RAM write port starting at address 0. The processor is held in reset during loading and released only after a complete, valid image has been written.

## Interface
Parameters:
- ADDR_W, 10, instruction memory address width; capacity is 2^ADDR_W words.
- WORD_W, 32, instruction word width; fixed at 4 bytes.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE.
- rx_valid  in  1  input byte valid.
- rx_data  in  8  input byte.
- rx_ready  out  1  loader can accept a byte this cycle.
- mem_we  out  1  instruction RAM write enable, one-cycle pulse per word.
- mem_addr  out  ADDR_W  write word address.
- mem_wdata  out  WORD_W  write word.
- cpu_reset  out  1  processor reset; high while not loaded or loading.
- busy  out  1  load in progress.
- done  out  1  last load completed successfully; sticky until next start.
- err  out  1  last load failed; sticky until next start.

## Operation
- Stream format: LEN_LO, LEN_HI (N = 16-bit word count), then 4·N data bytes. Word k uses bytes b0..b3, with b0 in bits [7:0].
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CHECK (CHECKSUM_EN only), FINISH.
- IDLE -> LEN_LO on start. This transition clears done, err, the word index and the byte index.
- LEN_LO -> LEN_HI when a byte is accepted.
- LEN_HI: on byte acceptance:
  - N = 0 or N > 2^ADDR_W -> IDLE with err=1.
  - Otherwise -> DATA.
- DATA:
  - A byte is accepted when rx_valid & rx_ready; the byte index (0..3) advances.
  - On the 4th byte, the assembled word is written at the word index, the word index increments and the byte index wraps to 0.
  - After word N-1 is written -> CHECK if enabled, else FINISH.
- FINISH: done=1 -> IDLE.
- Outputs per state:
  - rx_ready=1 in LEN_LO, LEN_HI, DATA and CHECK; 0 otherwise.
  - busy=1 in every state except IDLE.
  - cpu_reset=1 from reset and throughout any load. It goes to 0 only on a successful FINISH. It returns to 1 on the next start or on err.
- start while busy is ignored.
- Bytes offered in IDLE or FINISH are not accepted (rx_ready=0).
- Reset mid-load: all state is discarded and the FSM enters IDLE. No partial write is issued after reset.
- Address wrap is impossible because N ≤ 2^ADDR_W; the word index is ADDR_W+1 bits wide internally.

## Timing
- Reset values: rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, busy=0, done=0, err=0.
- All outputs are registered.
- start sampled at edge t -> state LEN_LO, rx_ready=1 and busy=1 after edge t.
- 4th byte of a word accepted at edge t -> mem_we=1 with a stable mem_addr/mem_wdata during the cycle after edge t. This gives one cycle of latency.
- mem_we is never high for two consecutive cycles, so back-to-back words are at least 4 cycles apart.
- Final write at edge t (no checksum) -> FINISH after edge t -> done=1 and cpu_reset=0 after edge t+1.
- Minimum load time: 2 + 4N + 2 cycles with rx_valid held high.

## Configuration
- Macro PROGRAM_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit modulo-256 sum of all data bytes (the length bytes are excluded) is accumulated during DATA.
  - One extra trailer byte is accepted in CHECK.
  - Match -> FINISH.
  - Mismatch -> IDLE with err=1 and cpu_reset=1. The memory contents are left as written.
- Undefined: the CHECK state and the accumulator are absent; DATA goes directly to FINISH.

## Structure
- Shared package loader_pkg contains:
  - the state enum;
  - BYTES_PER_WORD=4;
  - the LEN field width (16);
  - the error-cause constants ERR_LEN, ERR_SUM.
- Sub-module word_assembler:
  - 2-bit byte index and a 32-bit shift/placement register;
  - inputs byte_valid, byte, clear;
  - outputs word, word_valid (a pulse on the 4th byte).
- The top level holds the FSM, the length and word counters, the checksum accumulator and the output registers.

## Test plan
- Reset with no stimulus -> cpu_reset=1, busy=0, done=0, err=0, mem_we=0.
- start, then bytes 02 00 | 78 56 34 12 | EF BE AD DE:
  - writes 0x12345678 at addr 0 and 0xDEADBEEF at addr 1, exactly 2 mem_we pulses;
  - then done=1, cpu_reset=0.
- Length bytes 00 00 -> err=1, no mem_we, cpu_reset=1, FSM back in IDLE. Length 01 04 (1025) -> same error response.
- Same N=1 load with rx_valid toggling every other cycle, plus a start pulse mid-load -> identical write, start ignored.
- Assert reset after 2 of 4 data bytes, then perform a fresh load of 01 00 AA BB CC DD -> only 0xDDCCBBAA at addr 0 is written, with no stale bytes.
- With CHECKSUM_EN, N=1 data 01 02 03 04:
  - trailer 0A -> done=1;
  - trailer 0B -> err=1 and cpu_reset stays 1.
